dot_product_ctrl: RTL and testbench

Sequencer for a dot-product engine built around two single-cycle-latency read memories: vector A and vector B.
- On start, it reads the element pair at each address, multiplies each pair as signed values and accumulates the products.
- It returns the scalar result through a valid/ready handshake.
- It sits between the memory pair and the downstream result FIFO/consumer.
- It drives only the memory read ports. Memory loading is outside this block.

---
 rtl/dot_product_pkg.sv | 9 +
 rtl/dot_product_mac.sv | 31 +++
 rtl/dot_product_ctrl.sv | 99 +++++++++
 tb/tb_dot_product_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// dot_product_pkg: shared FSM states, default widths and accumulator sizing for the dot-product engine
package dot_product_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
  function automatic int acc_width(input int dw, input int aw);
    return 2 * dw + aw + 1;
  endfunction
endpackage

// File: rtl/dot_product_mac.sv
// dot_mac: registered signed multiply-accumulate
// Ports: clk, rst_n (sync, active-low), clear (zero acc, wins over en),
//        en (add a*b), a/b (signed operands), acc (running sum)
module dot_mac
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  always_comb begin
    prod  = $signed(a) * $signed(b);
    acc_d = clear ? '0
          : en ? acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod}
          : acc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  end
  assign acc = acc_q;
endmodule

// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: sequences paired A/B memory reads and returns their signed dot product
// Ports: clk, rst_n (sync, active-low); start/base_addr/vec_len request;
//        busy; mem_rd_en/mem_rd_addr shared read port, mem_a_data/mem_b_data one cycle later;
//        result/result_valid/result_ready output handshake
module dot_product_ctrl
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   vec_len,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_a_data,
  input  logic [DATA_WIDTH-1:0] mem_b_data,
  output logic [ACC_WIDTH-1:0]  result,
  input  logic                  result_ready,
  output logic                  result_valid
);
  state_e state_q, state_d;
  logic [ADDR_WIDTH:0] len_q, len_d, k_q, k_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic rd_en_q, rd_en_d, valid_q, valid_d, data_vld_q, clear, last;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    k_d     = k_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    valid_d = valid_q;
    clear   = 1'b0;
    last    = k_q == len_q - 1'b1;
    case (state_q)
      IDLE: if (start) begin
        clear   = 1'b1;
        len_d   = vec_len;
        k_d     = '0;
        addr_d  = base_addr;
        rd_en_d = vec_len != '0;
        valid_d = vec_len == '0;
        state_d = vec_len == '0 ? DONE : READ;
      end
      READ: begin
        rd_en_d = !last;
        addr_d  = last ? addr_q : addr_q + 1'b1;
        k_d     = last ? k_q : k_q + 1'b1;
        state_d = last ? DRAIN : READ;
      end
      // the last read's data is summed on this edge, so the accumulator is final next cycle
      DRAIN: begin
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (result_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      valid_q    <= valid_d;
      data_vld_q <= rd_en_q;
    end
  end
  assign busy         = state_q != IDLE;
  assign mem_rd_en    = rd_en_q;
  assign mem_rd_addr  = addr_q;
  assign result_valid = valid_q;
  // the accumulator doubles as the result register: it is frozen from DRAIN until the next start
  dot_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .en   (data_vld_q),
    .a    (mem_a_data),
    .b    (mem_b_data),
    .acc  (result)
  );
endmodule

// File: tb/tb_dot_product_ctrl.sv
// tb_dot_product_ctrl: scoreboard bench for dot_product_ctrl against a plain-arithmetic reference
module tb_dot_product_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2 * DW + AW + 1;
  logic clk = 0, rst_n = 0, start = 0, result_ready = 1;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] vec_len = '0;
  logic busy, mem_rd_en, result_valid;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_a_data = '0, mem_b_data = '0;
  logic [CW-1:0] result;
  logic [DW-1:0] mem_a[32], mem_b[32];
  logic [AW-1:0] addr_exp[$];
  logic [CW-1:0] res_exp[$];
  int checks = 0, fails = 0;
  dot_product_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .vec_len(vec_len),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
    .result(result), .result_ready(result_ready), .result_valid(result_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) begin
    mem_a_data <= mem_a[mem_rd_addr];
    mem_b_data <= mem_b[mem_rd_addr];
  end
  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [CW-1:0] ref_dot(input int base, input int len);
    logic signed [CW-1:0] s = 0, x, y;
    for (int i = 0; i < len; i++) begin
      x = $signed(mem_a[(base + i) % 32]);
      y = $signed(mem_b[(base + i) % 32]);
      s += x * y;
    end
    return s;
  endfunction
  always @(negedge clk) begin
    if (mem_rd_en) begin
      if (addr_exp.size() == 0) begin
        checks++; fails++;
        $display("FAIL rd_unexpected: read of addr %0d with none expected", mem_rd_addr);
      end else chk("rd_addr", CW'(mem_rd_addr), CW'(addr_exp.pop_front()));
    end
    if (result_valid && result_ready) begin
      if (res_exp.size() == 0) begin
        checks++; fails++;
        $display("FAIL res_unexpected: result %0h with none expected", result);
      end else chk("result", result, res_exp.pop_front());
    end
  end
  task automatic fill_rand();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
  endtask
  task automatic op(input int base, input int len, input int hold, input bit poke);
    int cyc;
    logic [CW-1:0] r0;
    res_exp.push_back(ref_dot(base, len));
    for (int i = 0; i < len; i++) addr_exp.push_back(AW'((base + i) % 32));
    result_ready = hold == 0;
    base_addr = AW'(base);
    vec_len = (AW + 1)'(len);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 1;
    while (!result_valid && cyc < 100) begin
      start = poke && cyc == 2;
      base_addr = base_addr + 3;
      vec_len = 1;
      @(posedge clk); #1;
      start = 0;
      cyc++;
    end
    chk("latency", CW'(cyc), CW'(len == 0 ? 1 : len + 2));
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      start = i == 1;
      @(posedge clk); #1;
      start = 0;
      chk("hold_valid", CW'(result_valid), 1);
      chk("hold_result", result, r0);
      chk("hold_busy", CW'(busy), 1);
    end
    result_ready = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("post_valid", CW'(result_valid), 0);
    chk("post_busy", CW'(busy), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    fill_rand();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", CW'(busy), 0);
    chk("rst_rd_en", CW'(mem_rd_en), 0);
    chk("rst_valid", CW'(result_valid), 0);
    chk("rst_addr", CW'(mem_rd_addr), 0);
    chk("rst_result", result, 0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = i + 1;
      mem_b[i] = i + 5;
    end
    op(0, 4, 0, 0);
    mem_a[0] = -3; mem_a[1] = 32'h7FFF_FFFF;
    mem_b[0] = 4;  mem_b[1] = 32'h7FFF_FFFF;
    op(0, 2, 0, 0);
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 1;
      mem_b[i] = 1;
    end
    op(30, 32, 0, 0);
    op(7, 0, 0, 0);
    fill_rand();
    op(3, 8, 5, 1);
    addr_exp.push_back(10);
    addr_exp.push_back(11);
    base_addr = 10;
    vec_len = 8;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("abort_busy", CW'(busy), 0);
    chk("abort_rd_en", CW'(mem_rd_en), 0);
    chk("abort_valid", CW'(result_valid), 0);
    chk("abort_result", result, 0);
    fill_rand();
    op(10, 8, 0, 0);
    repeat (25) begin
      fill_rand();
      op($urandom_range(0, 31), $urandom_range(0, 32), $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0,
         1'($urandom_range(0, 1)));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("addr_drained", CW'(addr_exp.size()), 0);
    chk("result_drained", CW'(res_exp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
